// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: EXE-stage multiply/divide sequencer owning HI/LO, with MADD/MSUB accumulation,
// MTHI/MTLO writes, and flush handling that drains an in-flight divide.
module md_seq_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        pipe_stall,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_prod,
  output logic        div_valid,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_ready,
  input  logic        div_out_valid,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  typedef enum logic [2:0] {IDLE, MUL, DREQ, DWAIT, DONE, DRAIN} state_t;
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_kind;
  logic        r_div_signed;
  logic [31:0] r_hi, r_lo, r_dvd, r_dvs;
  logic        w_is_mul, w_is_div, w_issue;
  logic [1:0]  w_kind;
  logic [63:0] w_acc, w_mres;
  assign w_is_mul = (md_op >= 4'd1) && (md_op <= 4'd6);
  assign w_is_div = (md_op == 4'd7) || (md_op == 4'd8);
  assign w_issue  = (r_state == IDLE) && (w_is_mul || w_is_div) && !flush;
  assign w_kind   = {(md_op == 4'd5) || (md_op == 4'd6), (md_op == 4'd3) || (md_op == 4'd4)};
  // Same-cycle MTHI/MTLO data is forwarded into the accumulator base
  assign w_acc    = {wr_hi ? wr_data : r_hi, wr_lo ? wr_data : r_lo};
  assign w_mres   = r_kind[0] ? w_acc + mul_prod : r_kind[1] ? w_acc - mul_prod : mul_prod;
  assign mul_signed   = w_is_mul && md_op[0];
  assign mul_x        = src_a;
  assign mul_y        = src_b;
  assign div_valid    = r_state == DREQ;
  assign div_signed   = r_div_signed;
  assign div_dividend = r_dvd;
  assign div_divisor  = r_dvs;
  assign hi_o         = r_hi;
  assign lo_o         = r_lo;
  // Stall must rise in the issue cycle itself, so it is decoded combinationally
  assign stall_o = (r_state == IDLE)  ? w_issue :
                   (r_state == MUL)   ? (r_cnt != 3'd0) :
                   (r_state == DREQ)  ? 1'b1 :
                   (r_state == DWAIT) ? !div_out_valid :
                   (r_state == DRAIN) ? (w_is_mul || w_is_div) : 1'b0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_kind       <= 2'd0;
      r_div_signed <= 1'b0;
      r_hi         <= 32'd0;
      r_lo         <= 32'd0;
      r_dvd        <= 32'd0;
      r_dvs        <= 32'd0;
    end else begin
      if (wr_hi) r_hi <= wr_data;
      if (wr_lo) r_lo <= wr_data;
      case (r_state)
        IDLE: if (w_issue) begin
          r_state <= w_is_mul ? MUL : DREQ;
          r_cnt   <= 3'(MUL_LAT - 1);
          r_kind  <= w_kind;
          if (w_is_div) begin
            r_dvd        <= src_a;
            r_dvs        <= src_b;
            r_div_signed <= md_op[0];
          end
        end
        MUL: if (flush) r_state <= IDLE;
          else if (r_cnt == 3'd0) begin
            {r_hi, r_lo} <= w_mres;
            r_state      <= pipe_stall ? DONE : IDLE;
          end else r_cnt <= r_cnt - 3'd1;
        DREQ: if (div_ready) r_state <= flush ? DRAIN : DWAIT;
          else if (flush) r_state <= IDLE;
        DWAIT: if (div_out_valid) begin
            if (!flush) {r_hi, r_lo} <= {div_rem, div_quot};
            r_state <= (!flush && pipe_stall) ? DONE : IDLE;
          end else if (flush) r_state <= DRAIN;
        DONE:  if (flush || !pipe_stall) r_state <= IDLE;
        DRAIN: if (div_out_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb_md_seq_ctrl: directed checks of md_seq_ctrl with a 1-cycle multiplier model and a
// hand-driven divider handshake.
module tb_md_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] src_a = 32'd0, src_b = 32'd0, wr_data = 32'd0;
  logic        flush = 1'b0, pipe_stall = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic        mul_signed, div_valid, div_signed, stall_o;
  logic [31:0] mul_x, mul_y, div_dividend, div_divisor, hi_o, lo_o;
  logic [63:0] mul_prod = 64'd0;
  logic        div_ready = 1'b0, div_out_valid = 1'b0;
  logic [31:0] div_quot = 32'd0, div_rem = 32'd0;
  int          checks = 0, passes = 0, hs_cnt = 0;

  md_seq_ctrl #(.MUL_LAT(1)) dut (
    .clk(clk), .rst(rst), .md_op(md_op), .src_a(src_a), .src_b(src_b), .flush(flush),
    .pipe_stall(pipe_stall), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y), .mul_prod(mul_prod),
    .div_valid(div_valid), .div_signed(div_signed), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_ready(div_ready), .div_out_valid(div_out_valid),
    .div_quot(div_quot), .div_rem(div_rem), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Multiplier model: 64-bit product of sign/zero-extended operands, one cycle after sampling
  always @(posedge clk)
    mul_prod <= {{32{mul_signed & mul_x[31]}}, mul_x} * {{32{mul_signed & mul_y[31]}}, mul_y};

  always @(posedge clk)
    if (div_valid && div_ready) hs_cnt <= hs_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    #1;
    checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passes++;
    checks++; if ({hi_o, lo_o} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {hi_o, lo_o}); else passes++;
    checks++; if (div_valid !== 1'b0) $display("FAIL reset_div_valid: got %b want 0", div_valid); else passes++;
    checks++; if ({div_dividend, div_divisor} !== 64'd0) $display("FAIL reset_operands: got %h want 0", {div_dividend, div_divisor}); else passes++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_mult();
    md_op = 4'd1; src_a = 32'hFFFF_FFFE; src_b = 32'd3;
    #1;
    checks++; if (stall_o !== 1'b1) $display("FAIL mult_issue_stall: got %b want 1", stall_o); else passes++;
    checks++; if (mul_signed !== 1'b1) $display("FAIL mult_signed: got %b want 1", mul_signed); else passes++;
    checks++; if (mul_x !== 32'hFFFF_FFFE) $display("FAIL mult_x: got %h want fffffffe", mul_x); else passes++;
    step();
    checks++; if (stall_o !== 1'b0) $display("FAIL mult_release: got %b want 0", stall_o); else passes++;
    step();
    md_op = 4'd0;
    #1;
    checks++; if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFA) $display("FAIL mult_result: got %h want fffffffffffffffa", {hi_o, lo_o}); else passes++;
  endtask

  task automatic test_madd_msub();
    wr_hi = 1'b1; wr_data = 32'd0;
    step();
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'hFFFF_FFFF;
    step();
    wr_lo = 1'b0;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0000_FFFF_FFFF) $display("FAIL mtlo_mthi: got %h want 00000000ffffffff", {hi_o, lo_o}); else passes++;
    md_op = 4'd4; src_a = 32'd1; src_b = 32'd1;
    #1;
    checks++; if (mul_signed !== 1'b0) $display("FAIL maddu_unsigned: got %b want 0", mul_signed); else passes++;
    step();
    step();
    md_op = 4'd0;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0001_0000_0000) $display("FAIL maddu_carry: got %h want 0000000100000000", {hi_o, lo_o}); else passes++;
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'd0;
    step();
    wr_hi = 1'b0; wr_lo = 1'b0;
    md_op = 4'd5; src_a = 32'd1; src_b = 32'd1;
    step();
    step();
    md_op = 4'd0;
    checks++; if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL msub_borrow: got %h want ffffffffffffffff", {hi_o, lo_o}); else passes++;
  endtask

  task automatic test_forward();
    wr_hi = 1'b1; wr_data = 32'd9;
    step();
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'd0;
    step();
    wr_lo = 1'b0;
    md_op = 4'd3; src_a = 32'd2; src_b = 32'd3;
    step();
    wr_hi = 1'b1; wr_data = 32'd5;
    step();
    wr_hi = 1'b0; md_op = 4'd0;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0005_0000_0006) $display("FAIL madd_forward: got %h want 0000000500000006", {hi_o, lo_o}); else passes++;
    md_op = 4'd2; src_a = 32'd4; src_b = 32'd5;
    step();
    wr_lo = 1'b1; wr_data = 32'h0000_AAAA;
    step();
    wr_lo = 1'b0; md_op = 4'd0;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0000_0000_0014) $display("FAIL commit_wins: got %h want 0000000000000014", {hi_o, lo_o}); else passes++;
  endtask

  task automatic test_div();
    int hs0;
    int bad;
    hs0 = hs_cnt;
    bad = 0;
    md_op = 4'd7; src_a = 32'd7; src_b = 32'hFFFF_FFFE;
    step();
    src_a = 32'd0;
    #1;
    checks++; if ({div_valid, div_signed, stall_o} !== 3'b111) $display("FAIL div_req: got %b want 111", {div_valid, div_signed, stall_o}); else passes++;
    checks++; if ({div_dividend, div_divisor} !== 64'h0000_0007_FFFF_FFFE) $display("FAIL div_latch: got %h want 00000007fffffffe", {div_dividend, div_divisor}); else passes++;
    step();
    step();
    div_ready = 1'b1;
    step();
    div_ready = 1'b0;
    #1;
    checks++; if ({div_valid, stall_o} !== 2'b01) $display("FAIL div_wait: got %b want 01", {div_valid, stall_o}); else passes++;
    for (int i = 0; i < 19; i++) begin
      if (stall_o !== 1'b1 || div_valid !== 1'b0) bad++;
      step();
    end
    checks++; if (bad !== 0) $display("FAIL div_hold_stall: got %0d bad cycles want 0", bad); else passes++;
    div_out_valid = 1'b1; div_quot = 32'hFFFF_FFFD; div_rem = 32'd1;
    #1;
    checks++; if (stall_o !== 1'b0) $display("FAIL div_strobe_stall: got %b want 0", stall_o); else passes++;
    step();
    div_out_valid = 1'b0; md_op = 4'd0;
    #1;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0001_FFFF_FFFD) $display("FAIL div_result: got %h want 00000001fffffffd", {hi_o, lo_o}); else passes++;
    checks++; if (hs_cnt - hs0 !== 1) $display("FAIL div_handshakes: got %0d want 1", hs_cnt - hs0); else passes++;
  endtask

  task automatic test_flush();
    md_op = 4'd8; src_a = 32'd100; src_b = 32'd7;
    step();
    div_ready = 1'b1;
    step();
    div_ready = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    md_op = 4'd8; src_a = 32'd20; src_b = 32'd6;
    #1;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0001_FFFF_FFFD) $display("FAIL flush_hilo: got %h want 00000001fffffffd", {hi_o, lo_o}); else passes++;
    checks++; if ({stall_o, div_valid} !== 2'b10) $display("FAIL drain_stall: got %b want 10", {stall_o, div_valid}); else passes++;
    step();
    step();
    div_out_valid = 1'b1; div_quot = 32'h0000_DEAD; div_rem = 32'h0000_BEEF;
    #1;
    checks++; if (stall_o !== 1'b1) $display("FAIL drain_strobe_stall: got %b want 1", stall_o); else passes++;
    step();
    div_out_valid = 1'b0;
    #1;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0001_FFFF_FFFD) $display("FAIL drain_discard: got %h want 00000001fffffffd", {hi_o, lo_o}); else passes++;
    step();
    checks++; if ({div_valid, div_signed, div_dividend} !== {2'b10, 32'd20}) $display("FAIL divu_reissue: got %h want %h", {div_valid, div_signed, div_dividend}, {2'b10, 32'd20}); else passes++;
    div_ready = 1'b1;
    step();
    div_ready = 1'b0;
    step();
    div_out_valid = 1'b1; div_quot = 32'd3; div_rem = 32'd2;
    step();
    div_out_valid = 1'b0; md_op = 4'd0;
    checks++; if ({hi_o, lo_o} !== 64'h0000_0002_0000_0003) $display("FAIL divu_after_drain: got %h want 0000000200000003", {hi_o, lo_o}); else passes++;
    md_op = 4'd1; src_a = 32'd5; src_b = 32'd5;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; md_op = 4'd0;
    #1;
    checks++; if ({stall_o, hi_o, lo_o} !== {1'b0, 64'h0000_0002_0000_0003}) $display("FAIL mul_flush: got %h want 00000000200000003", {stall_o, hi_o, lo_o}); else passes++;
  endtask

  task automatic test_back_to_back();
    md_op = 4'd1; src_a = 32'd3; src_b = 32'd4;
    step();
    pipe_stall = 1'b1;
    step();
    checks++; if ({stall_o, hi_o, lo_o} !== {1'b0, 64'd12}) $display("FAIL done_commit: got %h want %h", {stall_o, hi_o, lo_o}, {1'b0, 64'd12}); else passes++;
    step();
    wr_lo = 1'b1; wr_data = 32'h77;
    step();
    wr_lo = 1'b0;
    #1;
    checks++; if ({stall_o, lo_o} !== {1'b0, 32'h77}) $display("FAIL done_single_commit: got %h want %h", {stall_o, lo_o}, {1'b0, 32'h77}); else passes++;
    step();
    pipe_stall = 1'b0;
    step();
    md_op = 4'd1; src_a = 32'd6; src_b = 32'd7;
    #1;
    checks++; if (stall_o !== 1'b1) $display("FAIL idle_after_done: got %b want 1", stall_o); else passes++;
    step();
    step();
    md_op = 4'd1; src_a = 32'd2; src_b = 32'd2;
    #1;
    checks++; if ({stall_o, lo_o} !== {1'b1, 32'd42}) $display("FAIL b2b_issue: got %h want %h", {stall_o, lo_o}, {1'b1, 32'd42}); else passes++;
    step();
    step();
    md_op = 4'd0;
    checks++; if ({hi_o, lo_o} !== 64'd4) $display("FAIL b2b_result: got %h want 4", {hi_o, lo_o}); else passes++;
  endtask

  task automatic test_reset_mid();
    wr_hi = 1'b1; wr_data = 32'h55;
    step();
    wr_hi = 1'b0;
    md_op = 4'd7; src_a = 32'd1; src_b = 32'd1;
    step();
    rst = 1'b0; md_op = 4'd0;
    step();
    rst = 1'b1;
    #1;
    checks++; if ({div_valid, stall_o, hi_o, div_dividend} !== 66'd0) $display("FAIL reset_mid: got %h want 0", {div_valid, stall_o, hi_o, div_dividend}); else passes++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_madd_msub();
    test_forward();
    test_div();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
